enemy_swarm: RTL and testbench
==============================

ENEMY_SWARM -- requirements
Module: enemy_swarm

Interface
REQ-001 SHALL have parameter N_ENEMY, default 3, number of independent enemies (1..8).
REQ-002 SHALL have parameter COLS, default 8, playfield column count (4..16); legal enemy position range 1..COLS-2.
REQ-003 SHALL have parameter POS_W, default 4, position field width; must satisfy 2**POS_W >= COLS.
REQ-004 SHALL have parameter SEED, default 32'h0000_1234, LCG reset value.
REQ-005 SHALL have parameter RESPAWN_TICKS, default 4, dead-time in move ticks before respawn (1..15).
REQ-006 clk  input  1  system clock; all state changes on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 tick  input  1  one-cycle move strobe; enemies move only on cycles with tick=1.
REQ-009 hit_valid  input  1  one-cycle shot strobe.
REQ-010 hit_col  input  POS_W  column of shot, sampled when hit_valid=1.
REQ-011 enemy_pos  output  N_ENEMY*POS_W  packed positions, enemy i in bits [i*POS_W +: POS_W].
REQ-012 alive  output  N_ENEMY  bit i=1 when enemy i is alive.
REQ-013 hit_ack  output  1  one-cycle pulse, cycle after a shot that killed an enemy.
REQ-014 hit_idx  output  3  index of enemy killed; valid while hit_ack=1.
REQ-015 kill_count  output  8  total kills, saturating at 255.

Function
REQ-016 SHALL hold a 32-bit LCG r; on each tick, r <= r*1103515245 + 12345 (mod 2**32).
REQ-017 SHALL derive enemy i direction bit d_i = bit (16+i) of the current (pre-update) r on tick.
REQ-018 On tick, alive enemy with d_i=0: pos<COLS-2 -> pos+1, else pos-1.
REQ-019 On tick, alive enemy with d_i=1: pos>1 -> pos-1, else pos+1.
REQ-020 Position SHALL never leave 1..COLS-2 for any sequence of ticks.
REQ-021 Shot SHALL hit alive enemy i when |pos_i - hit_col| <= 1, evaluated against pre-move positions.
REQ-022 When several enemies qualify, only the lowest index SHALL be killed; others unaffected.
REQ-023 Kill SHALL clear alive[i], load dead counter i with RESPAWN_TICKS, increment kill_count (saturating), register hit_idx, pulse hit_ack next cycle.
REQ-024 Shot hitting no alive enemy SHALL produce no hit_ack and no state change.
REQ-025 Enemy killed in a cycle with tick=1 SHALL not move in that cycle.
REQ-026 Dead enemy's enemy_pos SHALL hold its last position.
REQ-027 Per-enemy state SHALL be ALIVE or DEAD; ALIVE->DEAD on kill; DEAD->ALIVE per REQ-031.
REQ-028 hit_valid while no enemy alive SHALL be ignored.

Reset
REQ-029 While rst=0: r=SEED, all alive=1, enemy i pos = 1 + ((i*(COLS-2)/N_ENEMY) mod (COLS-2)), dead counters 0, kill_count 0, hit_ack 0, hit_idx 0.
REQ-030 Reset asserted mid-operation (any state, any pending hit_ack) SHALL take effect immediately; first tick after release uses r=SEED.

Configuration
REQ-031 Macro ENEMY_RESPAWN_EN defined: each tick decrements nonzero dead counters; counter reaching 0 sets alive[i]=1, pos_i=(COLS/2)-1, no move that tick.
REQ-032 Macro ENEMY_RESPAWN_EN undefined: dead enemies stay DEAD until reset; dead counters not implemented.

Verification
REQ-033 Reset, defaults: enemy_pos packed = {4'd5,4'd3,4'd1}, alive=3'b111, kill_count=0.
REQ-034 COLS=8, 10000 random ticks -> every enemy_pos field always within 1..6; r matches LCG model each tick.
REQ-035 Enemy0 at 1, enemy1 at 3, hit_valid with hit_col=2 -> next cycle hit_ack=1, hit_idx=0, alive=3'b110, kill_count=1; enemy1 alive.
REQ-036 hit_valid and tick same cycle, enemy2 at 5, hit_col=6 -> enemy2 killed, pos stays 5; enemies 0,1 move per LCG.
REQ-037 ENEMY_RESPAWN_EN defined, kill enemy0, 4 ticks -> alive[0]=1 after 4th tick, pos0=3; undefined -> alive[0] stays 0 after 100 ticks.
REQ-038 256 successful kills (respawn on) -> kill_count=255; assert rst mid-hit_ack -> hit_ack=0, kill_count=0 immediately.

Source files
------------

// File: rtl/enemy_swarm.sv
// enemy_swarm: a row of N_ENEMY independent enemies that random-walk across a playfield
// and can be shot down.
//
// A 32-bit LCG advances on every move tick. Bit (16+i) of the pre-update value picks
// enemy i's direction. An enemy reflects at the edges, so it stays inside columns
// 1..COLS-2. A shot kills the lowest-indexed live enemy within one column of hit_col.
// Hits are evaluated against pre-move positions, and a killed enemy does not move
// in that cycle.
//
// Optional feature (macro ENEMY_RESPAWN_EN): dead enemies respawn at column
// (COLS/2)-1 after RESPAWN_TICKS move ticks. Without the macro, dead enemies stay
// dead until reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   tick       one-cycle move strobe
//   hit_valid  one-cycle shot strobe
//   hit_col    shot column (sampled with hit_valid)
//   enemy_pos  packed positions, enemy i at [i*POS_W +: POS_W]
//   alive      per-enemy alive flags
//   hit_ack    one-cycle pulse the cycle after a killing shot
//   hit_idx    index of the enemy killed (valid with hit_ack)
//   kill_count saturating total kill count
module enemy_swarm #(
  parameter int unsigned N_ENEMY       = 3,
  parameter int unsigned COLS          = 8,
  parameter int unsigned POS_W         = 4,
  parameter logic [31:0] SEED          = 32'h0000_1234,
  parameter int unsigned RESPAWN_TICKS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       hit_valid,
  input  logic [POS_W-1:0]           hit_col,
  output logic [N_ENEMY*POS_W-1:0]   enemy_pos,
  output logic [N_ENEMY-1:0]         alive,
  output logic                       hit_ack,
  output logic [2:0]                 hit_idx,
  output logic [7:0]                 kill_count
);

  localparam logic [31:0]      LcgMul = 32'd1103515245;
  localparam logic [31:0]      LcgInc = 32'd12345;
  localparam logic [POS_W-1:0] PosMin = POS_W'(1);
  localparam logic [POS_W-1:0] PosMax = POS_W'(COLS - 2);

  // Elaboration-time parameter sanity checks.
  if (N_ENEMY < 1 || N_ENEMY > 8) begin : g_bad_n_enemy
    $error("enemy_swarm: N_ENEMY must be 1..8");
  end
  if (COLS < 4 || COLS > 16 || (1 << POS_W) < COLS) begin : g_bad_cols
    $error("enemy_swarm: COLS must be 4..16 and fit in POS_W bits");
  end
  if (RESPAWN_TICKS < 1 || RESPAWN_TICKS > 15) begin : g_bad_respawn
    $error("enemy_swarm: RESPAWN_TICKS must be 1..15");
  end

  // Spread enemies evenly over the legal range at reset.
  function automatic logic [POS_W-1:0] init_pos(int unsigned idx);
    return POS_W'(1 + ((idx * (COLS - 2) / N_ENEMY) % (COLS - 2)));
  endfunction

  function automatic logic [POS_W-1:0] abs_diff(logic [POS_W-1:0] a, logic [POS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // dir=0 prefers right, dir=1 prefers left; both bounce off the edge columns.
  function automatic logic [POS_W-1:0] step_pos(logic [POS_W-1:0] pos, logic dir);
    logic [POS_W-1:0] nxt;
    if (!dir) nxt = (pos < PosMax) ? pos + PosMin : pos - PosMin;
    else      nxt = (pos > PosMin) ? pos - PosMin : pos + PosMin;
    return nxt;
  endfunction

  logic [N_ENEMY-1:0][POS_W-1:0] pos_q, pos_d;
  logic [N_ENEMY-1:0]            alive_q, alive_d;
  logic [31:0]                   lcg_q, lcg_d;
  logic [7:0]                    kill_cnt_q, kill_cnt_d;
  logic                          hit_ack_q, hit_ack_d;
  logic [2:0]                    hit_idx_q, hit_idx_d;

`ifdef ENEMY_RESPAWN_EN
  localparam logic [3:0]         RespawnCnt = 4'(RESPAWN_TICKS);
  localparam logic [POS_W-1:0]   PosSpawn   = POS_W'(COLS / 2 - 1);
  logic [N_ENEMY-1:0][3:0]       dead_cnt_q, dead_cnt_d;
`endif

  logic [N_ENEMY-1:0] near;
  logic [N_ENEMY-1:0] kill_oh;
  logic               kill;
  logic [2:0]         kill_idx;

  // Shot resolution: only live enemies qualify, lowest index wins.
  always_comb begin
    near     = '0;
    kill_oh  = '0;
    kill     = 1'b0;
    kill_idx = 3'd0;
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      near[i] = alive_q[i] && (abs_diff(pos_q[i], hit_col) <= PosMin);
    end
    for (int i = 0; i < int'(N_ENEMY); i++) begin
      if (hit_valid && near[i] && !kill) begin
        kill       = 1'b1;
        kill_idx   = 3'(i);
        kill_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pos_d      = pos_q;
    alive_d    = alive_q;
    lcg_d      = lcg_q;
    kill_cnt_d = kill_cnt_q;
    hit_ack_d  = kill;
    hit_idx_d  = kill ? kill_idx : hit_idx_q;
`ifdef ENEMY_RESPAWN_EN
    dead_cnt_d = dead_cnt_q;
`endif

    if (tick) lcg_d = lcg_q * LcgMul + LcgInc;

    if (kill && kill_cnt_q != 8'hFF) kill_cnt_d = kill_cnt_q + 8'd1;

    for (int i = 0; i < int'(N_ENEMY); i++) begin
      if (kill_oh[i]) begin
        // A freshly killed enemy freezes in place, even on a tick.
        alive_d[i] = 1'b0;
`ifdef ENEMY_RESPAWN_EN
        dead_cnt_d[i] = RespawnCnt;
`endif
      end else if (tick && alive_q[i]) begin
        pos_d[i] = step_pos(pos_q[i], lcg_q[16+i]);
      end
`ifdef ENEMY_RESPAWN_EN
      else if (tick && !alive_q[i] && dead_cnt_q[i] != 4'd0) begin
        dead_cnt_d[i] = dead_cnt_q[i] - 4'd1;
        if (dead_cnt_q[i] == 4'd1) begin
          // Respawn replaces the move for this tick.
          alive_d[i] = 1'b1;
          pos_d[i]   = PosSpawn;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(N_ENEMY); i++) begin
        pos_q[i] <= init_pos(i);
      end
      alive_q    <= '1;
      lcg_q      <= SEED;
      kill_cnt_q <= 8'd0;
      hit_ack_q  <= 1'b0;
      hit_idx_q  <= 3'd0;
    end else begin
      pos_q      <= pos_d;
      alive_q    <= alive_d;
      lcg_q      <= lcg_d;
      kill_cnt_q <= kill_cnt_d;
      hit_ack_q  <= hit_ack_d;
      hit_idx_q  <= hit_idx_d;
    end
  end

`ifdef ENEMY_RESPAWN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dead_cnt_q <= '0;
    else      dead_cnt_q <= dead_cnt_d;
  end
`endif

  assign enemy_pos  = pos_q;
  assign alive      = alive_q;
  assign hit_ack    = hit_ack_q;
  assign hit_idx    = hit_idx_q;
  assign kill_count = kill_cnt_q;

endmodule

// File: tb/tb_enemy_swarm.sv
// Self-checking bench for enemy_swarm (default parameters). A behavioural model
// tracks each enemy as integers and applies the game rules directly.
module tb_enemy_swarm;
  localparam int N    = 3;
  localparam int COLS = 8;
  localparam int W    = 4;
  localparam int RT   = 4;
  localparam logic [31:0] SEED = 32'h0000_1234;

  logic           clk = 1'b0;
  logic           rst;
  logic           tick;
  logic           hit_valid;
  logic [W-1:0]   hit_col;
  logic [N*W-1:0] enemy_pos;
  logic [N-1:0]   alive;
  logic           hit_ack;
  logic [2:0]     hit_idx;
  logic [7:0]     kill_count;

  enemy_swarm dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .hit_valid  (hit_valid),
    .hit_col    (hit_col),
    .enemy_pos  (enemy_pos),
    .alive      (alive),
    .hit_ack    (hit_ack),
    .hit_idx    (hit_idx),
    .kill_count (kill_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int          m_pos[N];
  bit          m_alive[N];
  int          m_cnt[N];
  logic [31:0] m_r;
  int          m_kc;
  bit          m_ack;
  int          m_idx;
  int          m_kills;

`ifdef ENEMY_RESPAWN_EN
  localparam bit RESPAWN = 1'b1;
`else
  localparam bit RESPAWN = 1'b0;
`endif

  function automatic logic [N*W-1:0] exp_pos();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_pos[i]);
    return v;
  endfunction

  function automatic logic [N-1:0] exp_alive();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pos[i]   = 1 + ((i * (COLS - 2) / N) % (COLS - 2));
      m_alive[i] = 1'b1;
      m_cnt[i]   = 0;
    end
    m_r   = SEED;
    m_kc  = 0;
    m_ack = 1'b0;
    m_idx = 0;
  endtask

  task automatic model_step(input bit t, input bit hv, input int hc);
    int  victim;
    bit  was_alive[N];
    victim = -1;
    for (int i = 0; i < N; i++) was_alive[i] = m_alive[i];
    if (hv) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (m_alive[i] && (m_pos[i] - hc <= 1) && (hc - m_pos[i] <= 1)) victim = i;
      end
    end
    m_ack = (victim >= 0);
    if (victim >= 0) begin
      m_alive[victim] = 1'b0;
      m_cnt[victim]   = RT;
      m_kc            = (m_kc < 255) ? m_kc + 1 : 255;
      m_idx           = victim;
      m_kills++;
    end
    if (t) begin
      for (int i = 0; i < N; i++) begin
        if (i == victim) continue;
        if (was_alive[i]) begin
          if (m_r[16+i] == 1'b0) m_pos[i] = (m_pos[i] < COLS - 2) ? m_pos[i] + 1 : m_pos[i] - 1;
          else                   m_pos[i] = (m_pos[i] > 1) ? m_pos[i] - 1 : m_pos[i] + 1;
        end else if (RESPAWN && m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_alive[i] = 1'b1;
            m_pos[i]   = COLS / 2 - 1;
          end
        end
      end
      m_r = m_r * 32'd1103515245 + 32'd12345;
    end
  endtask

  // Drive one cycle of stimulus; returns at posedge+1 with the model updated.
  task automatic step(input bit t, input bit hv, input int hc);
    tick      = t;
    hit_valid = hv;
    hit_col   = W'(hc);
    @(posedge clk);
    model_step(t, hv, hc);
    #1;
    tick      = 1'b0;
    hit_valid = 1'b0;
    hit_col   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    model_reset();
    checks++;
    if (enemy_pos !== 12'h531) begin
      errors++;
      $display("FAIL reset_pos got=%h want=%h", enemy_pos, 12'h531);
    end
    checks++;
    if (alive !== 3'b111) begin
      errors++;
      $display("FAIL reset_alive got=%b want=111", alive);
    end
    checks++;
    if (kill_count !== 8'd0 || hit_ack !== 1'b0 || hit_idx !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs got kc=%0d ack=%b idx=%0d want 0/0/0", kill_count, hit_ack,
               hit_idx);
    end
    checks++;
    if (dut.lcg_q !== SEED) begin
      errors++;
      $display("FAIL reset_lcg got=%h want=%h", dut.lcg_q, SEED);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_random_walk();
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      step($urandom_range(0, 3) != 0, 1'b0, 0);
      checks++;
      if (enemy_pos !== exp_pos()) begin
        errors++;
        $display("FAIL walk_pos n=%0d got=%h want=%h", n, enemy_pos, exp_pos());
      end
      checks++;
      if (dut.lcg_q !== m_r) begin
        errors++;
        $display("FAIL walk_lcg n=%0d got=%h want=%h", n, dut.lcg_q, m_r);
      end
      for (int i = 0; i < N; i++) begin
        checks++;
        if (enemy_pos[i*W +: W] < 4'd1 || enemy_pos[i*W +: W] > 4'(COLS - 2)) begin
          errors++;
          $display("FAIL walk_range n=%0d enemy=%0d got=%0d want 1..%0d", n, i,
                   enemy_pos[i*W +: W], COLS - 2);
        end
      end
    end
  endtask

  task automatic test_random_shots();
    for (int rep = 0; rep < 8; rep++) begin
      do_reset();
      for (int n = 0; n < 60; n++) begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, COLS - 1));
        checks++;
        if (enemy_pos !== exp_pos() || alive !== exp_alive() || kill_count !== 8'(m_kc)
            || hit_ack !== m_ack || (m_ack && hit_idx !== 3'(m_idx))) begin
          errors++;
          $display("FAIL shots rep=%0d n=%0d got pos=%h al=%b kc=%0d ack=%b idx=%0d want pos=%h al=%b kc=%0d ack=%b idx=%0d",
                   rep, n, enemy_pos, alive, kill_count, hit_ack, hit_idx, exp_pos(),
                   exp_alive(), m_kc, m_ack, m_idx);
        end
      end
    end
  endtask

  task automatic test_hit_lowest();
    do_reset();
    step(1'b0, 1'b1, 2);
    checks++;
    if (hit_ack !== 1'b1 || hit_idx !== 3'd0) begin
      errors++;
      $display("FAIL hit_lowest_ack got ack=%b idx=%0d want ack=1 idx=0", hit_ack, hit_idx);
    end
    checks++;
    if (alive !== 3'b110 || kill_count !== 8'd1) begin
      errors++;
      $display("FAIL hit_lowest_state got alive=%b kc=%0d want alive=110 kc=1", alive, kill_count);
    end
    step(1'b0, 1'b0, 0);
    checks++;
    if (hit_ack !== 1'b0) begin
      errors++;
      $display("FAIL hit_ack_pulse got=%b want=0", hit_ack);
    end
  endtask

  task automatic test_hit_and_tick();
    do_reset();
    step(1'b1, 1'b1, 6);
    checks++;
    if (alive !== 3'b011 || hit_ack !== 1'b1 || hit_idx !== 3'd2) begin
      errors++;
      $display("FAIL hit_tick_kill got alive=%b ack=%b idx=%0d want alive=011 ack=1 idx=2",
               alive, hit_ack, hit_idx);
    end
    checks++;
    if (enemy_pos[2*W +: W] !== 4'd5) begin
      errors++;
      $display("FAIL hit_tick_frozen got=%0d want=5", enemy_pos[2*W +: W]);
    end
    checks++;
    if (enemy_pos !== exp_pos()) begin
      errors++;
      $display("FAIL hit_tick_moves got=%h want=%h", enemy_pos, exp_pos());
    end
  endtask

  task automatic test_miss();
    do_reset();
    step(1'b0, 1'b1, 7);
    checks++;
    if (hit_ack !== 1'b0 || alive !== 3'b111 || kill_count !== 8'd0 || enemy_pos !== 12'h531) begin
      errors++;
      $display("FAIL miss got ack=%b alive=%b kc=%0d pos=%h want 0/111/0/531", hit_ack, alive,
               kill_count, enemy_pos);
    end
    // Kill everything, then shoot at an empty field.
    step(1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 3);
    step(1'b0, 1'b1, 5);
    step(1'b0, 1'b1, 3);
    checks++;
    if (hit_ack !== 1'b0 || alive !== 3'b000 || kill_count !== 8'd3) begin
      errors++;
      $display("FAIL none_alive got ack=%b alive=%b kc=%0d want 0/000/3", hit_ack, alive,
               kill_count);
    end
  endtask

  task automatic test_respawn();
    do_reset();
    step(1'b0, 1'b1, 0);
    checks++;
    if (alive !== 3'b110) begin
      errors++;
      $display("FAIL respawn_kill got=%b want=110", alive);
    end
    for (int n = 1; n <= (RESPAWN ? RT : 100); n++) begin
      step(1'b1, 1'b0, 0);
      checks++;
      if (alive !== exp_alive() || enemy_pos !== exp_pos()) begin
        errors++;
        $display("FAIL respawn_tick n=%0d got al=%b pos=%h want al=%b pos=%h", n, alive,
                 enemy_pos, exp_alive(), exp_pos());
      end
    end
    checks++;
    if (RESPAWN) begin
      if (alive[0] !== 1'b1 || enemy_pos[W-1:0] !== 4'd3) begin
        errors++;
        $display("FAIL respawn_done got al0=%b pos0=%0d want al0=1 pos0=3", alive[0],
                 enemy_pos[W-1:0]);
      end
    end else begin
      if (alive[0] !== 1'b0 || enemy_pos[W-1:0] !== 4'd1) begin
        errors++;
        $display("FAIL stay_dead got al0=%b pos0=%0d want al0=0 pos0=1", alive[0],
                 enemy_pos[W-1:0]);
      end
    end
  endtask

  task automatic test_saturate_and_reset();
    int target;
    int budget;
    do_reset();
    m_kills = 0;
    budget  = 0;
    while (m_kills < (RESPAWN ? 260 : N) && budget < 5000) begin
      target = -1;
      for (int i = N - 1; i >= 0; i--) if (m_alive[i]) target = i;
      if (target >= 0) step(1'b0, 1'b1, m_pos[target]);
      else             step(1'b1, 1'b0, 0);
      budget++;
    end
    checks++;
    if (budget >= 5000) begin
      errors++;
      $display("FAIL kill_budget got kills=%0d want %0d", m_kills, RESPAWN ? 260 : N);
    end
    checks++;
    if (kill_count !== 8'(m_kc) || kill_count !== (RESPAWN ? 8'd255 : 8'(N))) begin
      errors++;
      $display("FAIL kill_sat got=%0d want=%0d", kill_count, RESPAWN ? 255 : N);
    end
    // Get a fresh kill pending and reset underneath it.
    do_reset();
    step(1'b0, 1'b1, 5);
    checks++;
    if (hit_ack !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_ack got=%b want=1", hit_ack);
    end
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (hit_ack !== 1'b0 || kill_count !== 8'd0 || alive !== 3'b111 || enemy_pos !== 12'h531) begin
      errors++;
      $display("FAIL async_reset got ack=%b kc=%0d alive=%b pos=%h want 0/0/111/531", hit_ack,
               kill_count, alive, enemy_pos);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, 0);
    checks++;
    if (dut.lcg_q !== m_r || enemy_pos !== exp_pos()) begin
      errors++;
      $display("FAIL first_tick_seed got lcg=%h pos=%h want lcg=%h pos=%h", dut.lcg_q,
               enemy_pos, m_r, exp_pos());
    end
  endtask

  initial begin
    rst       = 1'b0;
    tick      = 1'b0;
    hit_valid = 1'b0;
    hit_col   = '0;
    m_kills   = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_random_walk();
    test_random_shots();
    test_hit_lowest();
    test_hit_and_tick();
    test_miss();
    test_respawn();
    test_saturate_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
